// File: rtl/max_pool_stream.sv
// Streaming POOLxPOOL max pooling (stride POOL) over a row-major IMG_W x IMG_H frame.
// Define MAX_POOL_SIGNED_EN for two's-complement signed pixels; default is unsigned.
module max_pool_stream #(
  parameter int DEPTH = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int POOL  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEPTH-1:0] out_data,
  output logic             out_last
);
  localparam int NB = IMG_W / POOL;
  localparam int NR = IMG_H / POOL;
  localparam int KW = $clog2(POOL);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;

  logic [KW-1:0]    kx, ky;
  logic [BW-1:0]    bucket;
  logic [RW-1:0]    wrow;
  logic [DEPTH-1:0] partial [NB];

  logic             accept, kx_end, ky_end, b_end, r_end, first, done;
  logic [DEPTH-1:0] cur, merged;

  function automatic logic gt(input logic [DEPTH-1:0] a, input logic [DEPTH-1:0] b);
`ifdef MAX_POOL_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign in_ready = !out_valid || out_ready;
  // clear wins over a simultaneous beat: the pixel stays on the bus
  assign accept   = in_valid && in_ready && !clear;

  assign kx_end = (kx == KW'(POOL - 1));
  assign ky_end = (ky == KW'(POOL - 1));
  assign b_end  = (bucket == BW'(NB - 1));
  assign r_end  = (wrow == RW'(NR - 1));
  assign first  = (kx == '0) && (ky == '0);
  assign done   = kx_end && ky_end;

  always_comb begin
    cur    = partial[bucket];
    merged = in_data;
    if (!first && gt(cur, in_data)) merged = cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx     <= '0;
      ky     <= '0;
      bucket <= '0;
      wrow   <= '0;
    end else if (clear) begin
      kx     <= '0;
      ky     <= '0;
      bucket <= '0;
      wrow   <= '0;
    end else if (accept) begin
      if (kx_end) begin
        kx <= '0;
        if (b_end) begin
          bucket <= '0;
          if (ky_end) begin
            ky   <= '0;
            wrow <= r_end ? '0 : wrow + 1'b1;
          end else begin
            ky <= ky + 1'b1;
          end
        end else begin
          bucket <= bucket + 1'b1;
        end
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  // Partial maxima need no reset: the first pixel of each window overwrites its entry.
  always_ff @(posedge clk) begin
    if (accept) partial[bucket] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && done) begin
      out_valid <= 1'b1;
      out_data  <= merged;
      out_last  <= b_end && r_end;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench for max_pool_stream: table of frame patterns plus stall/reset/clear sequences.
module tb_max_pool_stream;
  localparam int DEPTH = 8, W = 6, H = 6, P = 3;
  localparam int NPIX = W * H;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic [DEPTH-1:0] in_data = '0, out_data;

  max_pool_stream #(.DEPTH(DEPTH), .IMG_W(W), .IMG_H(H), .POOL(P)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last));

  always #5 clk = ~clk;

  typedef struct { logic [DEPTH-1:0] d; logic l; } exp_t;
  typedef struct { int mode; bit rdy_rand; bit vld_rand; logic [3:0][DEPTH-1:0] exp; } vec_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_idx = 0;
  bit pend_lat = 0;
  logic [3:0][DEPTH-1:0] exp_cur;
  vec_t tbl [6];

`ifdef MAX_POOL_SIGNED_EN
  localparam logic [DEPTH-1:0] SGN_EXP = 8'h05;
`else
  localparam logic [DEPTH-1:0] SGN_EXP = 8'hF0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DEPTH-1:0] pix(input int mode, input int i);
    int r, c;
    logic [DEPTH-1:0] w1 [9];
    logic [DEPTH-1:0] w2 [9];
    r = i / W; c = i % W;
    w1 = '{8'd10, 8'd20, 8'd5, 8'd40, 8'd15, 8'd60, 8'd25, 8'd30, 8'd50};
    w2 = '{8'd60, 8'd20, 8'd5, 8'd40, 8'd15, 8'd10, 8'd25, 8'd30, 8'd50};
    case (mode)
      1:       return (r < P && c < P) ? w1[r*P+c] : 8'd0;
      2:       return (r < P && c < P) ? w2[r*P+c] : 8'd0;
      3:       return (r == 1 && c == 1) ? 8'hF0 : 8'h05;
      default: return DEPTH'(W * r + c);
    endcase
  endfunction

  // Bench-side frame position; pushes the expected window result when its last pixel is accepted.
  task automatic model_accept();
    int r, c, wi;
    exp_t e;
    r = m_idx / W; c = m_idx % W;
    if ((r % P == P - 1) && (c % P == P - 1)) begin
      wi   = (r / P) * (W / P) + c / P;
      e.d  = exp_cur[wi];
      e.l  = (m_idx == NPIX - 1);
      sb.push_back(e);
      pend_lat = 1;
    end
    m_idx = (m_idx + 1) % NPIX;
  endtask

  // Called at a negedge after inputs are set; evaluates this cycle's handshakes, then advances.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    if (pend_lat) begin
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      pend_lat = 0;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
      end
    end
    acc = in_valid && in_ready && !clear;
    if (acc) model_accept();
    @(negedge clk);
  endtask

  task automatic send_px(input logic [DEPTH-1:0] d, input bit rdy_rand, input bit vld_rand);
    bit acc;
    for (int t = 0; t < 100; t++) begin
      in_valid  = vld_rand ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = d;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(acc);
      if (acc) return;
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && (sb.size() != 0 || out_valid); t++) tick(acc);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic set_ramp();
    exp_cur[0] = 8'd14; exp_cur[1] = 8'd17; exp_cur[2] = 8'd32; exp_cur[3] = 8'd35;
  endtask

  initial begin
    bit acc;
    tbl[0].mode = 0; tbl[0].rdy_rand = 0; tbl[0].vld_rand = 0;
    tbl[0].exp = {8'd35, 8'd32, 8'd17, 8'd14};
    tbl[1].mode = 1; tbl[1].rdy_rand = 0; tbl[1].vld_rand = 0;
    tbl[1].exp = {8'd0, 8'd0, 8'd0, 8'd60};
    tbl[2].mode = 2; tbl[2].rdy_rand = 0; tbl[2].vld_rand = 0;
    tbl[2].exp = {8'd0, 8'd0, 8'd0, 8'd60};
    tbl[3].mode = 0; tbl[3].rdy_rand = 1; tbl[3].vld_rand = 0;
    tbl[3].exp = {8'd35, 8'd32, 8'd17, 8'd14};
    tbl[4].mode = 3; tbl[4].rdy_rand = 0; tbl[4].vld_rand = 0;
    tbl[4].exp = {8'h05, 8'h05, 8'h05, SGN_EXP};
    tbl[5].mode = 0; tbl[5].rdy_rand = 1; tbl[5].vld_rand = 1;
    tbl[5].exp = {8'd35, 8'd32, 8'd17, 8'd14};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frames back-to-back, no idle cycle between table entries.
    for (int v = 0; v < 6; v++) begin
      exp_cur = tbl[v].exp;
      for (int i = 0; i < NPIX; i++) send_px(pix(tbl[v].mode, i), tbl[v].rdy_rand, tbl[v].vld_rand);
    end
    drain();

    // Output stall after the first completion: nothing may move.
    set_ramp();
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_data = DEPTH'(i); out_ready = 1'b0;
      tick(acc);
      if (!acc) chk("stall_pre_accept", 32'd0, 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'd15; out_ready = 1'b0;
      tick(acc);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_data", 32'(out_data), 32'd14);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    for (int i = 15; i < NPIX; i++) send_px(DEPTH'(i), 0, 0);
    drain();

    // Asynchronous reset mid-frame with an output pending.
    for (int i = 0; i < 18; i++) send_px(DEPTH'(i), 0, 0);
    in_valid = 1'b1; in_data = 8'd18; out_ready = 1'b0;
    #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0; sb.delete(); m_idx = 0; pend_lat = 0;
    for (int i = 0; i < NPIX; i++) send_px(DEPTH'(i), 0, 0);
    drain();

    // Synchronous clear mid-frame; the beat presented with clear is not consumed.
    for (int i = 0; i < 18; i++) send_px(DEPTH'(i), 0, 0);
    in_valid = 1'b1; in_data = 8'd200; out_ready = 1'b0; clear = 1'b1;
    sb.delete(); pend_lat = 0;
    tick(acc);
    chk("clear_not_consumed", 32'(acc), 32'd0);
    #1;
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    chk("clear_out_last", 32'(out_last), 32'd0);
    clear = 1'b0; m_idx = 0;
    for (int i = 0; i < NPIX; i++) send_px(DEPTH'(i), 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming, parametrised successor to the combinational window max selector.
- Accepts a row-major pixel stream of an IMG_W x IMG_H frame, one DEPTH-bit pixel per accepted beat.
- Emits the maximum of each non-overlapping POOL x POOL window (stride = POOL), using a one-row buffer of partial maxima instead of a full-window input bus.
- Sits between the convolution output stream and the next layer, with valid/ready on both sides.

Parameters:
- DEPTH, 8, pixel bit width.
- IMG_W, 6, frame width in pixels; must be a multiple of POOL.
- IMG_H, 6, frame height in pixels; must be a multiple of POOL.
- POOL, 3, window edge and stride; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame restart, same effect as reset except it does not act asynchronously.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_data  in  DEPTH  pixel value.
- out_valid  out  1  out_data holds a completed window maximum.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DEPTH  window maximum.
- out_last  out  1  qualifies out_data as the final window of the frame.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0. All counters are 0. Partial buffer contents are don't-care.
- A pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. There is a single output register and no skid buffer.
- Counters advance only on accept:
  - kx: 0..POOL-1
  - bucket: 0..IMG_W/POOL-1
  - ky: 0..POOL-1
  - wrow: 0..IMG_H/POOL-1
- Counter wrap rules:
  - kx wraps and increments bucket.
  - bucket wraps and increments ky.
  - ky wraps and increments wrow.
  - wrow wraps to 0 at end of frame; the next frame begins with no idle cycle.
- Partial buffer: IMG_W/POOL entries of DEPTH bits, indexed by bucket.
- Update rule on accept:
  - If kx==0 and ky==0: partial[bucket] <= in_data.
  - Otherwise: partial[bucket] <= max(partial[bucket], in_data).
  - Compare is unsigned by default. On equal values, either operand may be selected (same value).
- Window completion: accepting a pixel with kx==POOL-1 and ky==POOL-1 loads out_data <= max(partial[bucket], in_data) and sets out_valid=1 on the next edge. Latency is 1 cycle from the last window pixel.
- out_last is set with out_data when bucket, ky and wrow are all at their maximum values.
- Output handshake:
  - out_valid && out_ready with no new completion clears out_valid and out_last.
  - Output accept and a new completion in the same cycle reload the register, and out_valid stays 1.
  - out_data and out_last must stay stable while out_valid && !out_ready.
- Throughput: 1 pixel/cycle while the output drains every cycle.
- clear or rst mid-frame:
  - Partial frame is discarded and counters return to 0.
  - Any pending out_valid is dropped.
  - clear has priority over a simultaneous accept: the beat is not consumed.
- Pixels presented while in_ready=0 are not consumed and do not move counters.

Optional Feature:
- Macro: MAX_POOL_SIGNED_EN.
- When defined, pixels and comparisons are two's-complement signed; out_data is the signed maximum.
- When undefined, the compare is unsigned.
- The interface is identical in both builds.

Test Plan:
- Defaults, stream pixel = 6*row+col over one frame, out_ready=1 -> four outputs 14, 17, 32, 35 in that order. out_last=1 only on 35. Each out_valid appears 1 cycle after the accept of pixels (2,2), (2,5), (5,2), (5,5).
- First window holds {10,20,5,40,15,60,25,30,50} in row-major order (rest of frame = 0) -> first output 60. Repeat with 60 as the first pixel of the window -> 60 (checks the buffer-load path).
- Hold out_ready=0 after the first completion -> out_data stays 14 and in_ready=0; no counter moves despite in_valid=1. Raise out_ready -> 14 is consumed; streaming resumes; later outputs are unchanged.
- Assert rst asynchronously at pixel 20 of frame 1, then stream a full fresh frame -> out_valid drops immediately; next outputs are 14, 17, 32, 35 with no contamination. Repeat using clear.
- Second frame streamed back-to-back with no gap -> outputs 14, 17, 32, 35 again; out_last once per frame.
- Window with 8'hF0 and otherwise 8'h05 -> output 8'hF0 without the macro, 8'h05 with MAX_POOL_SIGNED_EN.
